// File: rtl/pe_input_feeder.sv
// West-edge feeder for the PE array: accepts input vectors, skews them diagonally
// (row r delayed r cycles), tags tile-first elements, and drains at tile end.
// Optional bubble counter enabled by defining PE_INPUT_FEEDER_BUBBLE_CNT_EN.
module pe_input_feeder #(
    parameter int ROWS   = 2,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     weights_loaded_in,
    input  logic                     vec_valid_in,
    output logic                     vec_ready_out,
    input  logic [ROWS*DATA_W-1:0]   vec_data_in,
    input  logic                     vec_last_in,
    output logic [ROWS-1:0]          row_valid_out,
    output logic [ROWS*DATA_W-1:0]   row_data_out,
    output logic [ROWS-1:0]          row_switch_out,
    output logic                     tile_done_out,
    output logic                     busy_out
`ifdef PE_INPUT_FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]              bubble_count_out
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) + 1 : 1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   drain_cnt_reg, drain_cnt_next;
    logic               tile_done_reg, tile_done_next;
    logic               ready_comb;
    logic               accept;
    logic               first_accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= '0;
            tile_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            tile_done_reg <= tile_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        tile_done_next = 1'b0;
        ready_comb     = 1'b0;
        first_accept   = 1'b0;

        case (state_reg)
            IDLE:    ready_comb = weights_loaded_in;
            STREAM:  ready_comb = 1'b1;
            default: ready_comb = 1'b0;
        endcase

        // Nothing is accepted while reset is being applied.
        accept = vec_valid_in & ready_comb & rst;

        case (state_reg)
            IDLE, STREAM: begin
                if (accept) begin
                    first_accept = (state_reg == IDLE);
                    if (vec_last_in) begin
                        if (ROWS == 1) begin
                            state_next     = IDLE;
                            tile_done_next = 1'b1;
                        end else begin
                            state_next     = DRAIN;
                            drain_cnt_next = CNT_W'(ROWS - 1);
                        end
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_reg <= CNT_W'(1)) begin
                    state_next     = IDLE;
                    tile_done_next = 1'b1;
                end else begin
                    drain_cnt_next = drain_cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign vec_ready_out = ready_comb & rst;
    assign busy_out      = (state_reg != IDLE);
    assign tile_done_out = tile_done_reg;

    // Row r carries a chain of r+1 registers; stage 0 loads at accept, last stage drives the row.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [DATA_W-1:0] data_pipe_reg [0:gi];
            logic [gi:0]       valid_pipe_reg;
            logic [gi:0]       switch_pipe_reg;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_pipe_reg  <= '0;
                    switch_pipe_reg <= '0;
                    for (int k = 0; k <= gi; k++) begin
                        data_pipe_reg[k] <= '0;
                    end
                end else begin
                    valid_pipe_reg[0]  <= accept;
                    switch_pipe_reg[0] <= accept & first_accept;
                    data_pipe_reg[0]   <= accept ? vec_data_in[gi*DATA_W +: DATA_W] : '0;
                    for (int k = 1; k <= gi; k++) begin
                        valid_pipe_reg[k]  <= valid_pipe_reg[k-1];
                        switch_pipe_reg[k] <= switch_pipe_reg[k-1];
                        data_pipe_reg[k]   <= data_pipe_reg[k-1];
                    end
                end
            end

            assign row_valid_out[gi]                  = valid_pipe_reg[gi];
            assign row_switch_out[gi]                 = switch_pipe_reg[gi];
            assign row_data_out[gi*DATA_W +: DATA_W]  = data_pipe_reg[gi];
        end
    endgenerate

`ifdef PE_INPUT_FEEDER_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt_reg <= '0;
        end else if (first_accept) begin
            bubble_cnt_reg <= '0;
        end else if (state_reg == STREAM && !vec_valid_in && bubble_cnt_reg != 16'hFFFF) begin
            bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign bubble_count_out = bubble_cnt_reg;
`endif

endmodule

// File: doc/pe_input_feeder.md
Name: pe_input_feeder

Overview:
Drives the west edge of the PE systolic array, acting as the source for each PE row's input stream: pe_input_in, pe_valid_in and pe_switch_in.
- Accepts whole input vectors (one Q8.8 element per row) through a valid/ready handshake.
- Skews them diagonally, so row r sees each vector r cycles after row 0.
- Tags the first vector of each tile with the weight-switch flag, so each PE promotes its inactive weight exactly when its first input of the tile arrives.
- Drains the skew pipeline at tile end and signals completion.

Parameters:
ROWS, 2, number of PE rows fed (>=1)
DATA_W, 16, element width (Q8.8 signed fixed point)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (rst=0 resets)
weights_loaded_in  in  1  inactive weights of all PEs are loaded; gates tile start
vec_valid_in  in  1  upstream vector valid
vec_ready_out  out  1  feeder accepts vector this cycle
vec_data_in  in  ROWS*DATA_W  element r at bits [r*DATA_W +: DATA_W]
vec_last_in  in  1  vector is last of tile
row_valid_out  out  ROWS  per-row pe_valid_in drive
row_data_out  out  ROWS*DATA_W  per-row pe_input_in drive
row_switch_out  out  ROWS  per-row pe_switch_in drive
tile_done_out  out  1  one-cycle pulse, last element reached row ROWS-1
busy_out  out  1  state != IDLE

Behaviour:
Reset and output registers:
- rst=0 at a clock edge: state=IDLE; all skew registers cleared; all outputs 0 (vec_ready_out=0 in the reset cycle).
- All row outputs are registered.

States:
- IDLE:
  - vec_ready_out=weights_loaded_in.
  - Accepted vector is the tile's first: switch tag=1. Next state = STREAM, or DRAIN if vec_last_in=1.
  - No accept: shift in bubble.
- STREAM:
  - vec_ready_out=1; weights_loaded_in ignored.
  - Accept with vec_last_in=1: next state = DRAIN.
  - vec_valid_in=0: bubble (valid=0, data=0, switch=0) shifted in. Skew is preserved; no stall.
- DRAIN:
  - vec_ready_out=0; bubbles shifted in for ROWS-1 cycles (down-counter).
  - On expiry: state=IDLE and tile_done_out=1 for one cycle.
  - ROWS=1: DRAIN is skipped. State goes straight to IDLE with tile_done_out registered on the accept edge.

Skew and timing:
- Vector accepted at edge N: row_*_out[0] reflects it after edge N; row r reflects it after edge N+r.
- tile_done_out is high in the same cycle row ROWS-1 presents the tile's last element.
- row_data_out is forced to 0 whenever the matching row_valid_out=0.
- The switch tag travels with the element: row_switch_out[r]=1 only alongside the first element of the tile on row r.
- No arithmetic; data is passed bit-exact.

Boundary conditions:
- Single-vector tile: switch=1 and last on the same vector, so tile_done coincides with its row ROWS-1 output.
- Next tile may be accepted in the cycle tile_done_out is high. Its row 0 element is never in the same slot as a prior-tile element.
- vec_valid_in with vec_ready_out=0: not accepted; upstream must hold it.
- Reset mid-tile: all in-flight elements are discarded; no tile_done pulse.

Optional Feature:
Macro: PE_INPUT_FEEDER_BUBBLE_CNT_EN
- Defined:
  - Adds port bubble_count_out (out, 16): counts STREAM cycles with vec_valid_in=0.
  - Saturates at 0xFFFF; cleared on tile-first accept and on reset.
  - Holds its value after the tile ends.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with vec_valid_in=1 -> all outputs 0, vec_ready_out=0, busy_out=0.
- Gating: rst=1, weights_loaded_in=0, vec_valid_in=1 for 5 cycles -> vec_ready_out=0 and row_valid_out=0 throughout.
- Two-vector tile, ROWS=2, vectors accepted at edges N and N+1: {r0=0x0200 (2.0), r1=0x0100} then {r0=0xFC9A (-3.3984375), r1=0x135C (19.359375), last=1}.
  - Row 0: 0x0200 with switch=1 after N, 0xFC9A with switch=0 after N+1.
  - Row 1: 0x0100 with switch=1 after N+1, 0x135C after N+2.
  - tile_done_out=1 only after N+2; vec_ready_out=0 in the DRAIN cycle.
- Bubble: in STREAM, one vec_valid_in=0 cycle between two vectors -> row 0 shows valid=0, data=0 for one slot, then row 1 one cycle later; bubble_count_out=1 with the macro defined.
- Single-vector tile, last=1, r0=0x0500, r1=0x0600 -> row 1 shows 0x0600 with switch=1 in the same cycle as tile_done_out=1; state returns to IDLE.
- Reset mid-tile: rst=0 one cycle after the first accept -> all row outputs 0 next cycle; tile_done_out never pulses; busy_out=0.
